// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC of the pipelined MIPS core.
// It chooses the next PC from these sources: sequential, branch, j/jal, jr,
// exception entry and eret. It also runs the req/ack handshake to instruction
// memory and presents each fetched word to IF/ID with a valid flag.
//
// Ports
//   clk, reset_n       : clock (rising edge), asynchronous active-low reset
//   stall              : hazard unit; hold IF outputs and issue no new fetch
//   redir_valid/pc_mux : ID-stage control transfer (0 +4, 1 br, 2 j, 3 jr)
//   imm32/addr26/ra32  : branch offset (words), jump field, jr target
//   exc_req/eret_req   : CP0 exception entry / return (epc = return target)
//   imem_req/imem_addr : fetch request; address is held stable until ack
//   imem_ack/imem_rdata: memory response
//   if_valid/if_instr/if_pc : IF/ID payload
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [1:0]  pc_mux,
  input  logic [31:0] imm32,
  input  logic [25:0] addr26,
  input  logic [31:0] ra32,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Priority of a control-flow event; the ordering is used for pending overrides.
  typedef enum logic [1:0] {
    P_NONE  = 2'd0,
    P_REDIR = 2'd1,
    P_ERET  = 2'd2,
    P_EXC   = 2'd3
  } pri_e;

  state_e            state, state_nxt;
  logic [XLEN-1:0]   pc, pc_nxt;
  pri_e              pend_pri, pend_pri_nxt;
  logic [XLEN-1:0]   pend_tgt, pend_tgt_nxt;
  logic              imem_req_nxt;
  logic              if_valid_nxt;
  logic [XLEN-1:0]   if_instr_nxt, if_pc_nxt;

  pri_e              evt_pri;
  logic [XLEN-1:0]   evt_tgt;
  logic [XLEN-1:0]   redir_base, redir_tgt;
  pri_e              mrg_pri;
  logic [XLEN-1:0]   mrg_tgt;

  assign imem_addr = pc;

  // Redirect targets are computed relative to the instruction currently in ID.
  always_comb begin : redir_calc
    redir_base = if_pc + XLEN'(4);
    redir_tgt  = redir_base;
    unique case (pc_mux)
      2'd0: redir_tgt = redir_base;
      2'd1: redir_tgt = redir_base + (imm32 << 2);
      2'd2: redir_tgt = {redir_base[31:28], addr26, 2'b00};
      2'd3: redir_tgt = ra32;
      default: redir_tgt = redir_base;
    endcase
  end

  // Highest-priority event arriving this cycle.
  always_comb begin : evt_sel
    evt_pri = P_NONE;
    evt_tgt = redir_tgt;
    if (exc_req) begin
      evt_pri = P_EXC;
      evt_tgt = EXC_VEC;
    end else if (eret_req) begin
      evt_pri = P_ERET;
      evt_tgt = epc;
    end else if (redir_valid) begin
      evt_pri = P_REDIR;
      evt_tgt = redir_tgt;
    end
  end

  // A new event replaces a pending one at equal or higher priority.
  always_comb begin : pend_merge
    mrg_pri = pend_pri;
    mrg_tgt = pend_tgt;
    if ((evt_pri != P_NONE) && (evt_pri >= pend_pri)) begin
      mrg_pri = evt_pri;
      mrg_tgt = evt_tgt;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_comb
    state_nxt    = state;
    pc_nxt       = pc;
    pend_pri_nxt = pend_pri;
    pend_tgt_nxt = pend_tgt;
    if_valid_nxt = if_valid;
    if_instr_nxt = if_instr;
    if_pc_nxt    = if_pc;

    unique case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (evt_pri != P_NONE) begin
          pc_nxt       = evt_tgt;
          if_valid_nxt = 1'b0;
        end
      end

      S_REQ: begin
        if (imem_ack) begin
          if (mrg_pri != P_NONE) begin
            // Squashed fetch: the word is dropped and the PC jumps.
            pc_nxt       = mrg_tgt;
            if_valid_nxt = 1'b0;
          end else begin
            pc_nxt       = pc + XLEN'(4);
            if_valid_nxt = 1'b1;
            if_instr_nxt = imem_rdata;
            if_pc_nxt    = pc;
          end
          pend_pri_nxt = P_NONE;
          state_nxt    = stall ? S_HOLD : S_REQ;
        end else if (evt_pri != P_NONE) begin
          // The request is in flight, so park the target until its ack returns.
          pend_pri_nxt = mrg_pri;
          pend_tgt_nxt = mrg_tgt;
          if_valid_nxt = 1'b0;
        end else if (!stall) begin
          if_valid_nxt = 1'b0;
        end
      end

      S_HOLD: begin
        if (evt_pri != P_NONE) begin
          pc_nxt       = evt_tgt;
          if_valid_nxt = 1'b0;
        end
        if (!stall) begin
          // ID consumes the held word on this edge.
          state_nxt    = S_REQ;
          if_valid_nxt = 1'b0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    imem_req_nxt = (state_nxt == S_REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin : seq
    if (!reset_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      pend_pri <= P_NONE;
      pend_tgt <= '0;
      imem_req <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_pri <= pend_pri_nxt;
      pend_tgt <= pend_tgt_nxt;
      imem_req <= imem_req_nxt;
      if_valid <= if_valid_nxt;
      if_instr <= if_instr_nxt;
      if_pc    <= if_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer. Instruction memory returns
// addr ^ 32'hC0DE_0000 so that each captured word identifies its address.
module tb_fetch_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redir_valid;
  logic [1:0]  pc_mux;
  logic [31:0] imm32;
  logic [25:0] addr26;
  logic [31:0] ra32;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_pc_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .redir_valid(redir_valid),
    .pc_mux     (pc_mux),
    .imm32      (imm32),
    .addr26     (addr26),
    .ra32       (ra32),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; sample/drive 1ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      imem_rdata = imem_addr ^ 32'hC0DE_0000;
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redir_valid = 1'b0; pc_mux = 2'd0;
    imm32 = '0; addr26 = '0; ra32 = '0; exc_req = 1'b0; eret_req = 1'b0;
    epc = '0; imem_ack = 1'b0; imem_rdata = '0;

    // Reset state
    step(2);
    check("rst_req",    32'(imem_req), 32'd0);
    check("rst_valid",  32'(if_valid), 32'd0);
    check("rst_instr",  if_instr,      32'h0);
    check("rst_ifpc",   if_pc,         32'h0);
    check("rst_addr",   imem_addr,     32'h0000_3000);

    // Sequential fetch, ack every cycle
    reset_n = 1'b1; imem_ack = 1'b1;
    step();
    check("seq0_req",   32'(imem_req), 32'd1);
    check("seq0_addr",  imem_addr,     32'h0000_3000);
    check("seq0_valid", 32'(if_valid), 32'd0);
    step();
    check("seq1_addr",  imem_addr,     32'h0000_3004);
    check("seq1_valid", 32'(if_valid), 32'd1);
    check("seq1_ifpc",  if_pc,         32'h0000_3000);
    check("seq1_instr", if_instr,      32'hC0DE_3000);
    step();
    check("seq2_addr",  imem_addr,     32'h0000_3008);
    check("seq2_ifpc",  if_pc,         32'h0000_3004);

    // Branch from if_pc=3004 with imm32=-2, coincident with ack
    redir_valid = 1'b1; pc_mux = 2'd1; imm32 = 32'hFFFF_FFFE;
    step();
    redir_valid = 1'b0;
    check("br_addr",    imem_addr,     32'h0000_3000);
    check("br_squash",  32'(if_valid), 32'd0);
    step();
    check("br_valid",   32'(if_valid), 32'd1);
    check("br_ifpc",    if_pc,         32'h0000_3000);
    check("br_next",    imem_addr,     32'h0000_3004);

    // Exception beats a simultaneous redirect; then eret
    exc_req = 1'b1; redir_valid = 1'b1; pc_mux = 2'd3; ra32 = 32'h1234_5678;
    step();
    exc_req = 1'b0; redir_valid = 1'b0;
    check("exc_addr",   imem_addr,     32'h0000_4180);
    check("exc_squash", 32'(if_valid), 32'd0);
    step();
    check("exc_ifpc",   if_pc,         32'h0000_4180);
    eret_req = 1'b1; epc = 32'h0000_3010;
    step();
    eret_req = 1'b0;
    check("eret_addr",  imem_addr,     32'h0000_3010);
    check("eret_squash",32'(if_valid), 32'd0);
    step();
    check("eret_ifpc",  if_pc,         32'h0000_3010);
    check("eret_instr", if_instr,      32'hC0DE_3010);
    check("eret_next",  imem_addr,     32'h0000_3014);

    // Jump while ack is delayed 3 cycles
    imem_ack = 1'b0; redir_valid = 1'b1; pc_mux = 2'd2; addr26 = 26'h000_0C00;
    step();
    redir_valid = 1'b0;
    check("jd_hold0",   imem_addr,     32'h0000_3014);
    check("jd_valid0",  32'(if_valid), 32'd0);
    step();
    check("jd_hold1",   imem_addr,     32'h0000_3014);
    step();
    check("jd_hold2",   imem_addr,     32'h0000_3014);
    check("jd_req2",    32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    step();
    check("jd_tgt",     imem_addr,     32'h0000_3000);
    check("jd_drop",    32'(if_valid), 32'd0);
    check("jd_ifpc",    if_pc,         32'h0000_3010);
    step();
    check("jd_valid",   32'(if_valid), 32'd1);
    check("jd_ifpc2",   if_pc,         32'h0000_3000);

    // Stall for 4 cycles; ack arrives in the first
    stall = 1'b1;
    step();
    imem_ack = 1'b0;
    check("st_ifpc",    if_pc,         32'h0000_3004);
    check("st_instr",   if_instr,      32'hC0DE_3004);
    check("st_req",     32'(imem_req), 32'd0);
    step(3);
    check("st_hold_in", if_instr,      32'hC0DE_3004);
    check("st_hold_v",  32'(if_valid), 32'd1);
    check("st_hold_rq", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    check("st_rel_req", 32'(imem_req), 32'd1);
    check("st_rel_adr", imem_addr,     32'h0000_3008);
    check("st_rel_v",   32'(if_valid), 32'd0);
    imem_ack = 1'b1;
    step();
    check("st_ifpc2",   if_pc,         32'h0000_3008);

    // Asynchronous reset in the middle of a request
    imem_ack = 1'b0;
    step();
    check("mr_req_pre", 32'(imem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_req",     32'(imem_req), 32'd0);
    check("mr_addr",    imem_addr,     32'h0000_3000);
    check("mr_valid",   32'(if_valid), 32'd0);
    imem_ack = 1'b1;
    step(2);
    reset_n = 1'b1;
    step();
    check("mr_restart", imem_addr,     32'h0000_3000);
    step();
    check("mr_ifpc",    if_pc,         32'h0000_3000);

    // Pending exception is not displaced by a later, lower-priority redirect
    imem_ack = 1'b0; exc_req = 1'b1;
    step();
    exc_req = 1'b0; redir_valid = 1'b1; pc_mux = 2'd0;
    step();
    redir_valid = 1'b0; imem_ack = 1'b1;
    step();
    check("pd_addr",    imem_addr,     32'h0000_4180);
    check("pd_drop",    32'(if_valid), 32'd0);

    // jr to the top of the address space; the next PC wraps to zero
    redir_valid = 1'b1; pc_mux = 2'd3; ra32 = 32'hFFFF_FFFC;
    step();
    redir_valid = 1'b0;
    check("wr_addr",    imem_addr,     32'hFFFF_FFFC);
    step();
    check("wr_ifpc",    if_pc,         32'hFFFF_FFFC);
    check("wr_instr",   if_instr,      32'h3F21_FFFC);
    check("wr_next",    imem_addr,     32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
